// File: rtl/keyboard_pkg.sv
// Shared constants and types for the keyboard polling controller.
package keyboard_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_RAND   = 2'd3;

  localparam logic [7:0] NO_KEY = 8'hFF;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;

  localparam int unsigned STAT_NONEMPTY  = 0;
  localparam int unsigned STAT_FULL      = 1;
  localparam int unsigned STAT_PRIMED    = 2;
  localparam int unsigned STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    StIdle,
    StPrime,
    StBurst
  } kbd_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head; push and pop may coincide.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // A push into a full FIFO is only legal when a pop frees the slot at the same edge.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;

  always_comb begin
    count_d = count_q;
    unique case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      count_q <= count_d;
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/keyboard_controller.sv
// Polls the user_input device in bursts, queues valid keycodes and exposes them
// through four memory-mapped word registers with a level interrupt.
module keyboard_controller #(
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned POLL_INTERVAL = 1000
) (
  input  logic        clock,
  input  logic        reset,
  output logic        dev_read,
  input  logic [31:0] dev_data,
  input  logic        cs,
  input  logic        we,
  input  logic [1:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);
  import keyboard_pkg::*;

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TW = (POLL_INTERVAL > 1) ? $clog2(POLL_INTERVAL) : 1;
  localparam logic [TW-1:0] RELOAD  = TW'(POLL_INTERVAL - 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  kbd_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic          primed_q, primed_d;
  logic [7:0]    rand_q, rand_d;
  logic          irq_q, irq_d;

  logic          push, pop, full, empty;
  logic [7:0]    head;
  logic [CW-1:0] count, count_nxt;
  logic          bus_rd, ctrl_wr, disabling;
  logic [7:0]    key;
  logic          unused_bits;

  assign key         = dev_data[31:24];
  assign bus_rd      = cs & ~we;
  assign ctrl_wr     = cs & we & (addr == REG_CTRL);
  assign disabling   = ctrl_wr & ~wdata[CTRL_ENABLE];
  assign pop         = bus_rd & (addr == REG_DATA) & ~empty;
  // Every BURST edge samples the result of the previous fetch.
  assign push        = (state_q == StBurst) & (key != NO_KEY);
  assign count_nxt   = count + CW'(push) - CW'(pop);
  assign irq         = irq_q;
  assign unused_bits = ^{dev_data[23:8], wdata[31:2]};

  sync_fifo #(
    .WIDTH(8),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clock(clock),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(key),
    .rdata(head),
    .full (full),
    .empty(empty),
    .count(count)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    ctrl_d   = ctrl_wr ? wdata[1:0] : ctrl_q;
    primed_d = primed_q;
    rand_d   = push ? dev_data[7:0] : rand_q;
    dev_read = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ctrl_q[CTRL_ENABLE]) begin
          if (timer_q != '0) begin
            timer_d = timer_q - TW'(1);
          end else if (!full) begin
            state_d = primed_q ? StBurst : StPrime;
          end else begin
            timer_d = RELOAD;
          end
        end
      end
      StPrime: begin
        dev_read = 1'b1;
        primed_d = 1'b1;
        state_d  = StBurst;
      end
      StBurst: begin
        dev_read = 1'b1;
        // Stopping at full guarantees dev_read is never high while the FIFO is full.
        if (key == NO_KEY || count_nxt == DEPTH_C || disabling || !ctrl_q[CTRL_ENABLE]) begin
          state_d = StIdle;
          timer_d = RELOAD;
        end
      end
      default: state_d = StIdle;
    endcase
    irq_d = ctrl_d[CTRL_IRQ_EN] & (count_nxt != '0);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      timer_q  <= RELOAD;
      ctrl_q   <= '0;
      primed_q <= 1'b0;
      rand_q   <= '0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      ctrl_q   <= ctrl_d;
      primed_q <= primed_d;
      rand_q   <= rand_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (bus_rd) begin
      unique case (addr)
        REG_CTRL:   rdata[1:0] = ctrl_q;
        REG_STATUS: begin
          rdata[STAT_NONEMPTY]                  = ~empty;
          rdata[STAT_FULL]                      = full;
          rdata[STAT_PRIMED]                    = primed_q;
          rdata[STAT_COUNT_LSB +: 8]            = 8'(count);
        end
        REG_DATA:   if (!empty) rdata[8:0] = {1'b1, head};
        REG_RAND:   rdata[7:0] = rand_q;
        default:    rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_keyboard_controller.sv
// Bench for keyboard_controller: behavioural user_input device plus a keycode scoreboard.
module tb_keyboard_controller;
  import keyboard_pkg::*;

  localparam int unsigned P = 8;
  localparam int unsigned D = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        dev_read, irq;
  logic        cs = 1'b0, we = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] wdata = '0, rdata, dev_data;
  logic [31:0] dev_out = 32'hDEAD_BE55;
  logic [31:0] dev_q [$];
  logic [31:0] exp_q [$];
  int          n_tests = 0, n_fail = 0;

  always #5 clock = ~clock;

  keyboard_controller #(
    .FIFO_DEPTH   (D),
    .POLL_INTERVAL(P)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .dev_read(dev_read),
    .dev_data(dev_data),
    .cs      (cs),
    .we      (we),
    .addr    (addr),
    .wdata   (wdata),
    .rdata   (rdata),
    .irq     (irq)
  );

  // Device: a read strobe at an edge fetches the next entry; "no key" once exhausted.
  assign dev_data = dev_out;
  always @(posedge clock) begin
    if (dev_read) begin
      if (dev_q.size() != 0) dev_out <= dev_q.pop_front();
      else                   dev_out <= {NO_KEY, 24'h0};
    end
  end

  function automatic logic [7:0] rnd(input logic [7:0] k);
    return k ^ 8'hA5;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] k, input bit expect_it);
    dev_q.push_back({k, 16'h0, rnd(k)});
    if (expect_it && k != NO_KEY) exp_q.push_back({23'h0, 1'b1, k});
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clock);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    @(posedge clock);
    #1 cs = 1'b0; we = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    @(negedge clock);
    cs = 1'b1; we = 1'b0; addr = a;
    #1 d = rdata;
    @(posedge clock);
    #1 cs = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(a, v);
    check_eq(tag, v, exp);
  endtask

  task automatic pop_check(input string tag);
    logic [31:0] v;
    bus_read(REG_DATA, v);
    if (exp_q.size() == 0) check_eq(tag, v, 32'h0);
    else                   check_eq(tag, v, exp_q.pop_front());
  endtask

  task automatic wait_rise(input string tag, input int budget, output int waited);
    waited = 0;
    while (dev_read !== 1'b1 && waited < budget) begin
      @(negedge clock);
      waited++;
    end
    if (dev_read !== 1'b1) check_eq({tag, "_timeout"}, 32'(dev_read), 32'h1);
  endtask

  task automatic burst_len(output int len);
    len = 0;
    while (dev_read === 1'b1 && len < 64) begin
      len++;
      @(negedge clock);
    end
  endtask

  task automatic idle_highs(input int cycles, output int highs);
    highs = 0;
    repeat (cycles) begin
      @(negedge clock);
      if (dev_read === 1'b1) highs++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int w, n;
    repeat (3) @(negedge clock);
    check_eq("rst_dev_read", 32'(dev_read), 32'h0);
    check_eq("rst_irq", 32'(irq), 32'h0);
    check_eq("rst_rdata", rdata, 32'h0);
    reset = 1'b0;
    read_check("rst_ctrl", REG_CTRL, 32'h0);
    read_check("rst_status", REG_STATUS, 32'h0);
    read_check("rst_rand", REG_RAND, 32'h0);

    // Prime discards the garbage sample; 41, 42 pushed; FF ends with 43 pending.
    load(8'h41, 1); load(8'h42, 1); load(NO_KEY, 1); load(8'h43, 1);
    bus_write(REG_CTRL, 32'h1);
    wait_rise("prime", 4 * P, w);
    check_eq("prime_delay", w, P + 1);
    burst_len(n);
    check_eq("burst1_len", n, 4);
    read_check("burst1_status", REG_STATUS, 32'h0000_0205);
    read_check("burst1_rand", REG_RAND, {24'h0, rnd(8'h42)});

    wait_rise("burst2", 4 * P, w);
    burst_len(n);
    check_eq("burst2_len", n, 2);
    bus_write(REG_CTRL, 32'h0);
    read_check("burst2_status", REG_STATUS, 32'h0000_0305);
    read_check("burst2_rand", REG_RAND, {24'h0, rnd(8'h43)});
    pop_check("pop_41");
    pop_check("pop_42");
    pop_check("pop_43");
    pop_check("pop_empty");
    read_check("drained_status", REG_STATUS, 32'h0000_0004);

    // Fill to depth, hold off while full, then resume in order after two pops.
    for (int k = 8'h51; k <= 8'h56; k++) load(8'(k), 1);
    bus_write(REG_CTRL, 32'h1);
    wait_rise("pend_ff", 4 * P, w);
    burst_len(n);
    check_eq("pend_ff_len", n, 1);
    wait_rise("fill", 4 * P, w);
    burst_len(n);
    check_eq("fill_len", n, 4);
    check_eq("full_read_low", 32'(dev_read), 32'h0);
    read_check("full_status", REG_STATUS, 32'h0000_0407);
    idle_highs(3 * P, n);
    check_eq("full_no_read", n, 0);
    bus_write(REG_CTRL, 32'h0);
    pop_check("pop_51");
    pop_check("pop_52");
    bus_write(REG_CTRL, 32'h1);
    wait_rise("refill", 4 * P, w);
    burst_len(n);
    check_eq("refill_len", n, 2);
    bus_write(REG_CTRL, 32'h0);
    read_check("refill_status", REG_STATUS, 32'h0000_0407);
    for (int k = 0; k < 4; k++) pop_check("pop_fill");
    read_check("fill_drained", REG_STATUS, 32'h0000_0004);

    // Interrupt follows the first push by one cycle and drops after the pop.
    load(8'h61, 1);
    bus_write(REG_CTRL, 32'h3);
    wait_rise("irq_pend", 4 * P, w);
    burst_len(n);
    check_eq("irq_pend_len", n, 1);
    wait_rise("irq_burst", 4 * P, w);
    check_eq("irq_pre", 32'(irq), 32'h0);
    @(negedge clock);
    check_eq("irq_rise", 32'(irq), 32'h1);
    burst_len(n);
    check_eq("irq_tail_len", n, 1);
    bus_write(REG_CTRL, 32'h2);
    check_eq("irq_hold", 32'(irq), 32'h1);
    pop_check("pop_61");
    check_eq("irq_fall", 32'(irq), 32'h0);

    // Clearing enable mid-burst keeps that edge's key and freezes the counter.
    load(8'h71, 1); load(8'h72, 1);
    bus_write(REG_CTRL, 32'h1);
    wait_rise("dis_pend", 4 * P, w);
    burst_len(n);
    wait_rise("dis_burst", 4 * P, w);
    bus_write(REG_CTRL, 32'h0);
    check_eq("dis_read_low", 32'(dev_read), 32'h0);
    read_check("dis_status", REG_STATUS, 32'h0000_0205);
    idle_highs(3 * P, n);
    check_eq("dis_no_read", n, 0);
    bus_write(REG_CTRL, 32'h1);
    wait_rise("dis_resume", 4 * P, w);
    check_eq("dis_counter_hold", w, P + 1);
    burst_len(n);
    check_eq("dis_resume_len", n, 1);
    bus_write(REG_CTRL, 32'h0);
    pop_check("pop_71");
    pop_check("pop_72");

    // Reset during a burst drops everything and forces a fresh prime.
    load(8'h81, 0); load(8'h82, 1); load(8'h83, 1);
    bus_write(REG_CTRL, 32'h1);
    wait_rise("rst_pend", 4 * P, w);
    burst_len(n);
    wait_rise("rst_burst", 4 * P, w);
    reset = 1'b1;
    #1 check_eq("rst_mid_read", 32'(dev_read), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    read_check("rst_mid_status", REG_STATUS, 32'h0);
    read_check("rst_mid_ctrl", REG_CTRL, 32'h0);
    bus_write(REG_CTRL, 32'h1);
    wait_rise("reprime", 4 * P, w);
    check_eq("reprime_delay", w, P + 1);
    burst_len(n);
    check_eq("reprime_len", n, 4);
    bus_write(REG_CTRL, 32'h0);
    read_check("reprime_status", REG_STATUS, 32'h0000_0205);
    read_check("reprime_rand", REG_RAND, {24'h0, rnd(8'h83)});
    pop_check("pop_82");
    pop_check("pop_83");
    pop_check("pop_final_empty");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
